alu_share_arbiter: RTL

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

---
 rtl/alu_share_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: two requesters share one external combinational ALU.
// One operation is in flight at a time. It moves through IDLE -> EXEC -> RESP.
// The result goes back to the requester that issued it. Requesters are served
// round-robin when both ask at the same time.
//
// Handshake semantics (both request and response channels):
//   A transfer happens on a rising clk edge where valid and ready are both high.
//   The request side is valid-driven: req_valid_k may rise or fall freely while
//   not granted, and the arbiter's req_ready_k depends combinationally on it.
//   The response side is ready-driven: once rsp_valid_k rises, it stays high and
//   rsp_data stays stable until the cycle in which rsp_ready_k is high.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  // requester 0
  input  logic             req_valid_0,
  output logic             req_ready_0,
  input  logic [WIDTH-1:0] req_a_0,
  input  logic [WIDTH-1:0] req_b_0,
  input  logic [OPW-1:0]   req_op_0,
  output logic             rsp_valid_0,
  input  logic             rsp_ready_0,
  // requester 1
  input  logic             req_valid_1,
  output logic             req_ready_1,
  input  logic [WIDTH-1:0] req_a_1,
  input  logic [WIDTH-1:0] req_b_1,
  input  logic [OPW-1:0]   req_op_1,
  output logic             rsp_valid_1,
  input  logic             rsp_ready_1,
  // shared result
  output logic [WIDTH-1:0] rsp_data,
  // shared ALU
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_s,
  // status
  output logic             busy,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  // prio names the requester that wins when both are valid.
  logic             prio;
  // owner is the requester whose operation is currently in flight.
  logic             owner;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] data_q;

  logic             grant_0;
  logic             grant_1;
  logic             rsp_done;

  // Pick a winner from the valid requesters. A lone requester wins outright,
  // so there is no idle cycle while the pointer is set to the other requester.
  always_comb begin
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    if (req_valid_0 && req_valid_1) begin
      grant_0 = ~prio;
      grant_1 = prio;
    end else begin
      grant_0 = req_valid_0;
      grant_1 = req_valid_1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs. Ready is offered only in IDLE and only
  // outside reset. The response is offered only to the owner.
  always_comb begin
    state_nxt   = state;
    req_ready_0 = 1'b0;
    req_ready_1 = 1'b0;
    rsp_valid_0 = 1'b0;
    rsp_valid_1 = 1'b0;
    rsp_done    = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        busy        = 1'b0;
        req_ready_0 = rst_n & grant_0;
        req_ready_1 = rst_n & grant_1;
        if (grant_0 || grant_1) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid_0 = ~owner;
        rsp_valid_1 = owner;
        rsp_done    = owner ? rsp_ready_1 : rsp_ready_0;
        if (rsp_done) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand latch, result capture and round-robin pointer. Operands change
  // only on accept, so the ALU inputs stay steady for the whole operation.
  // The response handshake hands priority to the other requester.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      owner  <= 1'b0;
      prio   <= 1'b0;
      data_q <= '0;
    end else begin
      if (req_ready_0) begin
        a_q   <= req_a_0;
        b_q   <= req_b_0;
        op_q  <= req_op_0;
        owner <= 1'b0;
      end else if (req_ready_1) begin
        a_q   <= req_a_1;
        b_q   <= req_b_1;
        op_q  <= req_op_1;
        owner <= 1'b1;
      end
      if (state == EXEC) begin
        data_q <= alu_s;
      end
      if (rsp_done) begin
        prio <= ~owner;
      end
    end
  end

  // The ALU is fed from the latched operands. The opcode reads as add (0)
  // while reset is held, before the registers have cleared.
  always_comb begin
    alu_a     = a_q;
    alu_b     = b_q;
    alu_op    = rst_n ? op_q : '0;
    rsp_data  = data_q;
    state_dbg = state;
  end

endmodule
